seq_detect_sched: RTL

Round-robin scheduler that shares one serial "1010" Mealy sequence detector between `NREQ` requesters. Each requester presents a `WIDTH`-bit word. The scheduler grants one requester and clears the detector. It then shifts the captured word into the detector MSB-first and counts the detector's match pulses, including overlapping matches. Finally it returns the count with a one-cycle `done` strobe. It sits between client logic and the detector instance, and owns the detector's `x` and `reset` inputs.

---
 rtl/seq_sched_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 41 ++++
 rtl/seq1010_det.sv | 45 ++++
 rtl/seq_detect_sched.sv | 133 +++++++++++++
 4 files changed

// File: rtl/seq_sched_pkg.sv
// Shared types and default sizing for the sequence-detector scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package seq_sched_pkg;

    // Job phases: idle, detector clear, serial shift, result strobe.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int DEF_NREQ  = 4;
    localparam int DEF_WIDTH = 8;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted req at or after ptr, wrapping.
// Latency: 0 cycles (pure logic; caller registers the result).
// Backpressure: none; gnt is all-zero when no req is asserted.
// Ports: req (NREQ requests), ptr (search start index), gnt (one-hot winner).
module rr_arbiter
    import seq_sched_pkg::*;
#(
    parameter  int NREQ = DEF_NREQ,
    localparam int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] gnt
);

    // One extra bit so ptr + offset never overflows before the wrap.
    localparam logic [PW:0] NREQ_W = (PW+1)'(NREQ);

    logic [PW:0]   sum;
    logic [PW-1:0] idx;
    logic          found;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            sum = {1'b0, ptr} + (PW+1)'(i);
            if (sum >= NREQ_W) begin
                sum = sum - NREQ_W;
            end
            idx = sum[PW-1:0];
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seq1010_det.sv
// Serial "1010" Mealy detector with overlap; y pulses on the final 0 of a match.
// Latency: y is combinational from state and x; state advances on each clk edge.
// Backpressure: none; one bit consumed per cycle. reset is synchronous, active-high.
// Ports: clk, reset (sync, high), x (serial bit in), y (match pulse out).
module seq1010_det (
    input  logic clk,
    input  logic reset,
    input  logic x,
    output logic y
);

    typedef enum logic [1:0] {
        S0   = 2'd0,   // nothing useful seen
        S1   = 2'd1,   // "1"
        S10  = 2'd2,   // "10"
        S101 = 2'd3    // "101"
    } det_state_t;

    det_state_t st, st_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            st <= S0;
        end else begin
            st <= st_nxt;
        end
    end

    always_comb begin
        st_nxt = st;
        y      = 1'b0;
        case (st)
            S0:   st_nxt = x ? S1 : S0;
            S1:   st_nxt = x ? S1 : S10;
            S10:  st_nxt = x ? S101 : S0;
            S101: begin
                // A completed "1010" leaves "10" as the prefix of the next match.
                st_nxt = x ? S1 : S10;
                y      = ~x;
            end
            default: st_nxt = S0;
        endcase
    end

endmodule

// File: rtl/seq_detect_sched.sv
// Round-robin scheduler sharing one serial "1010" detector among NREQ requesters.
// Latency: grant at edge k, first bit in cycle k+1, done strobe in cycle k+WIDTH+1.
// Backpressure: losers hold req; dropping the granted req mid-job aborts it (no done).
// Ports: clk, reset_n (sync, low); req/data from clients; grant/done/match_count back;
//        det_x/det_reset drive the detector, det_y is its Mealy output.
module seq_detect_sched
    import seq_sched_pkg::*;
#(
    parameter  int NREQ  = DEF_NREQ,
    parameter  int WIDTH = DEF_WIDTH,
    localparam int CW    = $clog2(WIDTH+1)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] data,
    output logic [NREQ-1:0]       grant,
    output logic                  done,
    output logic [CW-1:0]         match_count,
    output logic                  det_x,
    output logic                  det_reset,
    input  logic                  det_y
);

    localparam int PW = $clog2(NREQ);

    state_t           state, state_nxt;
    logic [PW-1:0]    ptr, ptr_nxt;
    logic [NREQ-1:0]  arb_gnt;
    logic [WIDTH-1:0] shreg, win_word;
    logic [CW-1:0]    bit_cnt, acc, acc_inc;
    logic             owner_lost;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req (req),
        .ptr (ptr),
        .gnt (arb_gnt)
    );

    // Winner's word and the pointer value that follows it.
    always_comb begin
        win_word = '0;
        ptr_nxt  = ptr;
        for (int i = 0; i < NREQ; i++) begin
            if (arb_gnt[i]) begin
                win_word = data[i*WIDTH +: WIDTH];
                ptr_nxt  = (i == NREQ-1) ? '0 : PW'(i+1);
            end
        end
    end

    // Saturating increment; unreachable for legal WIDTH but kept for safety.
    assign acc_inc    = (det_y && (acc != {CW{1'b1}})) ? acc + 1'b1 : acc;
    assign owner_lost = ((req & grant) == '0);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        det_x     = 1'b0;
        case (state)
            IDLE: begin
                if (|req) state_nxt = CLEAR;
            end
            CLEAR: begin
                state_nxt = owner_lost ? IDLE : SHIFT;
            end
            SHIFT: begin
                det_x = shreg[WIDTH-1];
                if (owner_lost) begin
                    state_nxt = IDLE;
                end else if (bit_cnt == CW'(WIDTH-1)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            grant       <= '0;
            ptr         <= '0;
            shreg       <= '0;
            bit_cnt     <= '0;
            acc         <= '0;
            match_count <= '0;
            det_reset   <= 1'b1;
        end else begin
            // Detector is cleared for exactly the CLEAR cycle of each job.
            det_reset <= (state_nxt == CLEAR);

            if (state_nxt == IDLE) begin
                grant <= '0;
            end

            case (state)
                IDLE: begin
                    if (|req) begin
                        grant   <= arb_gnt;
                        ptr     <= ptr_nxt;
                        shreg   <= win_word;
                        bit_cnt <= '0;
                        acc     <= '0;
                    end
                end
                SHIFT: begin
                    // det_y reflects the bit on det_x this cycle, so the last
                    // bit's match is folded in while loading the result.
                    acc     <= acc_inc;
                    shreg   <= {shreg[WIDTH-2:0], 1'b0};
                    bit_cnt <= bit_cnt + 1'b1;
                    if (state_nxt == DONE) begin
                        match_count <= acc_inc;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
